// File: rtl/axi_wr_mem.sv
// AXI4 write-channel slave memory: one AW/W/B burst at a time into a byte-strobed
// word array, plus a registered one-cycle-latency debug read port.
module axi_wr_mem #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int MEM_AW     = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    axi_slv_awvalid,
  output logic                    axi_slv_awready,
  input  logic [ID_WIDTH-1:0]     axi_slv_awid,
  input  logic [ADDR_WIDTH-1:0]   axi_slv_awaddr,
  input  logic [LEN_WIDTH-1:0]    axi_slv_awlen,
  input  logic [2:0]              axi_slv_awsize,
  input  logic [1:0]              axi_slv_awburst,
  input  logic                    axi_slv_awlock,
  input  logic [3:0]              axi_slv_awcache,
  input  logic [2:0]              axi_slv_awprot,
  input  logic [3:0]              axi_slv_awqos,
  input  logic [3:0]              axi_slv_awregion,
  input  logic                    axi_slv_wvalid,
  output logic                    axi_slv_wready,
  input  logic [DATA_WIDTH-1:0]   axi_slv_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi_slv_wstrb,
  input  logic                    axi_slv_wlast,
  output logic                    axi_slv_bvalid,
  input  logic                    axi_slv_bready,
  output logic [ID_WIDTH-1:0]     axi_slv_bid,
  output logic [1:0]              axi_slv_bresp,
  input  logic [MEM_AW-1:0]       dbg_addr,
  output logic [DATA_WIDTH-1:0]   dbg_rdata
);

  localparam int STRB     = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB);
  localparam int DEPTH    = 1 << MEM_AW;
  localparam logic [2:0] ADDR_LSB_3 = 3'(ADDR_LSB);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t                  state_reg;
  logic                    awready_reg;
  logic                    wready_reg;
  logic                    bvalid_reg;
  logic [ID_WIDTH-1:0]     bid_reg;
  logic [1:0]              bresp_reg;
  logic [ADDR_WIDTH-1:0]   cur_addr_reg;
  logic [LEN_WIDTH-1:0]    len_reg;
  logic [LEN_WIDTH-1:0]    beat_cnt_reg;
  logic [2:0]              size_reg;
  logic                    fixed_reg;
  logic                    size_err_reg;
  logic                    proto_err_reg;
  logic [DATA_WIDTH-1:0]   dbg_rdata_reg;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    beat;
  logic                    last_beat;
  logic                    wlast_bad;
  logic [MEM_AW-1:0]       word_idx;
  logic [ADDR_WIDTH-1:0]   addr_step;
  logic [STRB-1:0]         lane_we;

  assign beat      = (state_reg == S_DATA) && wready_reg && axi_slv_wvalid;
  assign last_beat = (beat_cnt_reg == len_reg);
  assign wlast_bad = (axi_slv_wlast != last_beat);
  assign word_idx  = cur_addr_reg[ADDR_LSB +: MEM_AW];
  assign addr_step = ADDR_WIDTH'(1) << size_reg;

  assign axi_slv_awready = awready_reg;
  assign axi_slv_wready  = wready_reg;
  assign axi_slv_bvalid  = bvalid_reg;
  assign axi_slv_bid     = bid_reg;
  assign axi_slv_bresp   = bresp_reg;
  assign dbg_rdata       = dbg_rdata_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      awready_reg   <= 1'b0;
      wready_reg    <= 1'b0;
      bvalid_reg    <= 1'b0;
      bid_reg       <= '0;
      bresp_reg     <= 2'b00;
      cur_addr_reg  <= '0;
      len_reg       <= '0;
      beat_cnt_reg  <= '0;
      size_reg      <= 3'd0;
      fixed_reg     <= 1'b0;
      size_err_reg  <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (axi_slv_awvalid && awready_reg) begin
            awready_reg   <= 1'b0;
            wready_reg    <= 1'b1;
            state_reg     <= S_DATA;
            bid_reg       <= axi_slv_awid;
            cur_addr_reg  <= axi_slv_awaddr;
            len_reg       <= axi_slv_awlen;
            size_reg      <= axi_slv_awsize;
            beat_cnt_reg  <= '0;
            fixed_reg     <= (axi_slv_awburst == 2'b00);
            size_err_reg  <= (axi_slv_awsize > ADDR_LSB_3);
            // WRAP and reserved burst types are executed as INCR but flagged
            proto_err_reg <= axi_slv_awburst[1];
          end else begin
            awready_reg <= 1'b1;
          end
        end
        S_DATA: begin
          if (beat) begin
            if (!fixed_reg) cur_addr_reg <= cur_addr_reg + addr_step;
            if (wlast_bad) proto_err_reg <= 1'b1;
            if (last_beat) begin
              wready_reg <= 1'b0;
              bvalid_reg <= 1'b1;
              state_reg  <= S_RESP;
              bresp_reg  <= (size_err_reg || proto_err_reg || wlast_bad) ? 2'b10 : 2'b00;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + LEN_WIDTH'(1);
            end
          end
        end
        S_RESP: begin
          if (axi_slv_bready) begin
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            state_reg   <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // An oversized beat suppresses the whole burst's writes; the length still counts.
  generate
    for (genvar gi = 0; gi < STRB; gi++) begin : g_lane
      assign lane_we[gi] = beat && !rst && axi_slv_wstrb[gi] && !size_err_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB; i++) begin
      if (lane_we[i]) mem[word_idx][i*8 +: 8] <= axi_slv_wdata[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dbg_rdata_reg <= '0;
    else     dbg_rdata_reg <= mem[dbg_addr];
  end

  logic unused_ok;
  assign unused_ok = ^{axi_slv_awlock, axi_slv_awcache, axi_slv_awprot,
                       axi_slv_awqos, axi_slv_awregion, cur_addr_reg};

endmodule

// File: tb/tb_axi_wr_mem.sv
// Directed bench for axi_wr_mem: bursts, strobes, backpressure, errors, reset.
module tb_axi_wr_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_rdata;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  axi_wr_mem dut (
    .clk(clk), .rst(rst),
    .axi_slv_awvalid(awvalid), .axi_slv_awready(awready), .axi_slv_awid(awid),
    .axi_slv_awaddr(awaddr), .axi_slv_awlen(awlen), .axi_slv_awsize(awsize),
    .axi_slv_awburst(awburst), .axi_slv_awlock(1'b0), .axi_slv_awcache(4'd0),
    .axi_slv_awprot(3'd0), .axi_slv_awqos(4'd0), .axi_slv_awregion(4'd0),
    .axi_slv_wvalid(wvalid), .axi_slv_wready(wready), .axi_slv_wdata(wdata),
    .axi_slv_wstrb(wstrb), .axi_slv_wlast(wlast),
    .axi_slv_bvalid(bvalid), .axi_slv_bready(bready), .axi_slv_bid(bid),
    .axi_slv_bresp(bresp), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] bt);
    int t = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = bt; awvalid = 1'b1;
    while (!awready && t < 50) begin tick(); t++; end
    if (!awready) check("aw_timeout", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int t = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    while (!wready && t < 50) begin tick(); t++; end
    if (!wready) check("w_timeout", 32'(wready), 32'd1);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_wait(input logic [3:0] id, input logic [1:0] resp);
    int t = 0;
    while (!bvalid && t < 50) begin tick(); t++; end
    check("b_valid", 32'(bvalid), 32'd1);
    check("b_id", 32'(bid), 32'(id));
    check("b_resp", 32'(bresp), 32'(resp));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_drop", 32'(bvalid), 32'd0);
  endtask

  task automatic dbg_read(input logic [9:0] idx, output logic [31:0] v);
    dbg_addr = idx;
    tick();
    v = dbg_rdata;
  endtask

  task automatic write1(input logic [31:0] addr, input logic [31:0] d);
    aw_send(4'd0, addr, 8'd0, 3'd2, 2'd1);
    w_beat(d, 4'hF, 1'b1);
    b_wait(4'd0, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0; dbg_addr = 0;
    repeat (3) tick();
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_bid", 32'(bid), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    check("rst_dbg", dbg_rdata, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_awready", 32'(awready), 32'd1);

    // single write
    aw_send(4'd3, 32'h10, 8'd0, 3'd2, 2'd1);
    check("aw_hs_wready", 32'(wready), 32'd1);
    check("aw_hs_awready", 32'(awready), 32'd0);
    w_beat(32'hDEADBEEF, 4'hF, 1'b1);
    check("b_latency", 32'(bvalid), 32'd1);
    check("b_wready_low", 32'(wready), 32'd0);
    b_wait(4'd3, 2'b00);
    check("idle_awready", 32'(awready), 32'd1);
    dbg_read(10'd4, rd); check("single_mem4", rd, 32'hDEADBEEF);

    // INCR burst with partial strobes over preloaded words
    write1(32'h108, 32'hAAAAAAAA);
    write1(32'h10C, 32'hBBBBBBBB);
    aw_send(4'd1, 32'h100, 8'd3, 3'd2, 2'd1);
    w_beat(32'h11111111, 4'hF, 1'b0);
    w_beat(32'h22222222, 4'hF, 1'b0);
    w_beat(32'h33333333, 4'h3, 1'b0);
    w_beat(32'h44444444, 4'hC, 1'b1);
    b_wait(4'd1, 2'b00);
    dbg_read(10'd64, rd); check("incr_mem64", rd, 32'h11111111);
    dbg_read(10'd65, rd); check("incr_mem65", rd, 32'h22222222);
    dbg_read(10'd66, rd); check("incr_mem66", rd, 32'hAAAA3333);
    dbg_read(10'd67, rd); check("incr_mem67", rd, 32'h4444BBBB);

    // FIXED burst with wvalid gaps
    write1(32'h24, 32'h00000099);
    aw_send(4'd4, 32'h20, 8'd2, 3'd2, 2'd0);
    w_beat(32'h0000000A, 4'hF, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("gap_wready", 32'(wready), 32'd1);
      check("gap_bvalid", 32'(bvalid), 32'd0);
      tick();
    end
    w_beat(32'h0000000B, 4'hF, 1'b0);
    check("fixed_not_done", 32'(bvalid), 32'd0);
    w_beat(32'h0000000C, 4'hF, 1'b1);
    b_wait(4'd4, 2'b00);
    dbg_read(10'd8, rd); check("fixed_mem8", rd, 32'h0000000C);
    dbg_read(10'd9, rd); check("fixed_mem9", rd, 32'h00000099);

    // B backpressure with a pending AW
    aw_send(4'd5, 32'h40, 8'd0, 3'd2, 2'd1);
    w_beat(32'h5555AAAA, 4'hF, 1'b1);
    awid = 4'd6; awaddr = 32'h44; awlen = 8'd0; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid", 32'(bvalid), 32'd1);
      check("bp_bid", 32'(bid), 32'd5);
      check("bp_bresp", 32'(bresp), 32'd0);
      check("bp_awready", 32'(awready), 32'd0);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bp_bdrop", 32'(bvalid), 32'd0);
    check("bp_awready_back", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0;
    check("bp_aw_taken", 32'(awready), 32'd0);
    check("bp_wready", 32'(wready), 32'd1);
    w_beat(32'h00000066, 4'hF, 1'b1);
    b_wait(4'd6, 2'b00);
    dbg_read(10'd16, rd); check("bp_mem16", rd, 32'h5555AAAA);
    dbg_read(10'd17, rd); check("bp_mem17", rd, 32'h00000066);

    // oversized beat: nothing written, SLVERR
    aw_send(4'd2, 32'h10, 8'd0, 3'd3, 2'd1);
    w_beat(32'h12345678, 4'hF, 1'b1);
    b_wait(4'd2, 2'b10);
    dbg_read(10'd4, rd); check("size_err_mem4", rd, 32'hDEADBEEF);

    // early wlast: length follows awlen, all beats written
    aw_send(4'd7, 32'h200, 8'd3, 3'd2, 2'd1);
    w_beat(32'h1, 4'hF, 1'b0);
    w_beat(32'h2, 4'hF, 1'b1);
    check("early_wlast_no_b", 32'(bvalid), 32'd0);
    w_beat(32'h3, 4'hF, 1'b0);
    w_beat(32'h4, 4'hF, 1'b1);
    b_wait(4'd7, 2'b10);
    for (int i = 0; i < 4; i++) begin
      dbg_read(10'(128 + i), rd); check("wlast_mem", rd, 32'(i + 1));
    end

    // WRAP handled as INCR, flagged
    aw_send(4'd8, 32'h300, 8'd1, 3'd2, 2'd2);
    w_beat(32'h77, 4'hF, 1'b0);
    w_beat(32'h88, 4'hF, 1'b1);
    b_wait(4'd8, 2'b10);
    dbg_read(10'd192, rd); check("wrap_mem192", rd, 32'h77);
    dbg_read(10'd193, rd); check("wrap_mem193", rd, 32'h88);

    // maximum length burst
    aw_send(4'd1, 32'h800, 8'd255, 3'd2, 2'd1);
    for (int i = 0; i < 256; i++) begin
      w_beat(32'(i), 4'hF, (i == 255));
      if (i == 254) check("max_not_done", 32'(bvalid), 32'd0);
    end
    b_wait(4'd1, 2'b00);
    dbg_read(10'd512, rd); check("max_first", rd, 32'd0);
    dbg_read(10'd640, rd); check("max_mid", rd, 32'd128);
    dbg_read(10'd767, rd); check("max_last", rd, 32'd255);

    // reset in the middle of a burst
    write1(32'h408, 32'h00005555);
    aw_send(4'd9, 32'h400, 8'd7, 3'd2, 2'd1);
    w_beat(32'h1000, 4'hF, 1'b0);
    w_beat(32'h2000, 4'hF, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    check("mid_rst_bvalid", 32'(bvalid), 32'd0);
    check("mid_rst_wready", 32'(wready), 32'd0);
    rst = 1'b0;
    tick();
    check("mid_rst_awready", 32'(awready), 32'd1);
    check("mid_rst_no_b", 32'(bvalid), 32'd0);
    dbg_read(10'd256, rd); check("mid_rst_mem256", rd, 32'h1000);
    dbg_read(10'd257, rd); check("mid_rst_mem257", rd, 32'h2000);
    dbg_read(10'd258, rd); check("mid_rst_mem258", rd, 32'h5555);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_wr_mem.md
Name: axi_wr_mem

Overview:
AXI4 write-channel slave memory (AW/W/B), the write-direction counterpart of the AR/R read path between core master and memory.
- Accepts one write burst at a time, commits byte-strobed beats into an internal word array, and returns a single B response per burst.
- Sits on the data-memory side of the SoC interconnect.
- Exposes a one-cycle-latency debug read port so benches can check memory contents without an AR/R path.

Parameters:
ID_WIDTH, 4, AXI ID width for awid/bid
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (power of two, ≥8); STRB = DATA_WIDTH/8
LEN_WIDTH, 8, awlen width
MEM_AW, 10, log2 of memory depth in words

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
axi_slv_awvalid  in  1  AW valid
axi_slv_awready  out  1  AW ready
axi_slv_awid  in  ID_WIDTH  write ID
axi_slv_awaddr  in  ADDR_WIDTH  start byte address
axi_slv_awlen  in  LEN_WIDTH  beats minus 1
axi_slv_awsize  in  3  log2 bytes per beat
axi_slv_awburst  in  2  0 = FIXED, 1 = INCR, 2 = WRAP, 3 = reserved
axi_slv_awlock/awcache/awprot/awqos/awregion  in  1/4/3/4/4  accepted and ignored
axi_slv_wvalid  in  1  W valid
axi_slv_wready  out  1  W ready
axi_slv_wdata  in  DATA_WIDTH  write data
axi_slv_wstrb  in  STRB  byte enables
axi_slv_wlast  in  1  last beat flag
axi_slv_bvalid  out  1  B valid
axi_slv_bready  in  1  B ready
axi_slv_bid  out  ID_WIDTH  echoed awid
axi_slv_bresp  out  2  00 = OKAY, 10 = SLVERR
dbg_addr  in  MEM_AW  debug word index
dbg_rdata  out  DATA_WIDTH  mem[dbg_addr], registered, 1-cycle latency

Behaviour:
Reset and outputs
- All outputs registered. While rst=1: awready=0, wready=0, bvalid=0, bid=0, bresp=00, dbg_rdata=0, FSM→IDLE. Memory array is not reset.

FSM
- IDLE: awready=1 from the first cycle after rst deasserts. On awvalid&awready, latch id, addr, len, size, burst and compute the error flag; next cycle awready=0, wready=1, state DATA.
- DATA: each cycle with wvalid&wready commits one beat at that edge.
  - Byte lane i is written iff wstrb[i]=1 and the error flag is clear.
  - Word index = cur_addr[ADDR_LSB+MEM_AW-1:ADDR_LSB], where ADDR_LSB = log2(STRB). Out-of-range addresses alias modulo depth.
  - Beat counter counts from 0. When the counter equals the latched len, that beat is final: next cycle wready=0, bvalid=1, state RESP.
- RESP: bvalid held with bid/bresp stable until bready. On bvalid&bready, next cycle bvalid=0, awready=1, state IDLE.
- awready and wready are never both 1; exactly one burst is in flight.

Address update after each beat
- FIXED: address unchanged.
- INCR and WRAP: cur_addr += (1<<size), modulo 2^ADDR_WIDTH; WRAP is not wrapped.

Error rules (bresp=10 if any holds; otherwise 00)
- size > ADDR_LSB: all writes of the burst suppressed.
- burst = 2 or 3: writes still performed as INCR.
- wlast=1 on a non-final beat, or wlast=0 on the final beat: burst length is governed solely by the counter. Beats are still written.

Timing and boundaries
- Latency: AW accepted at edge T; first beat may be accepted at edge T+1; bvalid rises the cycle after the final-beat edge. Minimum burst occupancy is len+3 cycles including the B handshake.
- wvalid gaps: wready stays 1 and the counter does not advance.
- awvalid asserted during DATA/RESP: ignored (awready=0) until IDLE.
- len = 0: a single beat, which is the final beat.
- len = max (256 beats): counter width LEN_WIDTH with no overflow.
- Debug port: dbg_rdata <= mem[dbg_addr] every cycle. A same-cycle write to the same index returns old data.
- rst during DATA or RESP: burst abandoned, already-written beats remain in memory, no B response issued.

Test Plan:
- Single write: AW addr=0x10, len=0, size=2, INCR, id=3; W data=0xDEADBEEF, strb=F, wlast=1 → bvalid one cycle after W edge, bid=3, bresp=00; dbg_addr=4 → 0xDEADBEEF.
- INCR burst: addr=0x100, len=3, size=2; data 0x11111111..0x44444444, strb F,F,3,C → mem[64..67] = 0x11111111, 0x22222222, xxxx3333 (upper half unchanged), 4444xxxx (lower half unchanged); bresp=00.
- FIXED burst: addr=0x20, len=2, data A,B,C → mem[8]=C, other words unchanged; wvalid deasserted 2 cycles between beats → counter holds, wready stays 1.
- Backpressure: bready held 0 for 5 cycles → bvalid/bid/bresp stable; a new awvalid during this time sees awready=0 and is accepted the cycle after the B handshake.
- Errors: size=3 with DATA_WIDTH=32 → no memory change, bresp=10. wlast=1 on beat 1 of a len=3 burst → 4 beats written, bresp=10. burst=2 → written as INCR, bresp=10.
- Reset mid-burst: rst pulsed after beat 2 of a len=7 INCR burst → first two words written, no bvalid, awready=1 the cycle after rst drops.
